branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised successor of the pipeline's branch-prediction block: a direct-mapped branch target buffer (BTB) plus a pattern table of saturating counters.
- Two combinational lookup ports serve the IF stage: one keyed by PC+2 (compressed instruction), one by PC+4 (32-bit instruction).
- One update port is driven by EX branch resolution.
- Adds what the current predictor lacks: configurable depth, tag and counter width, optional gshare indexing with a global history register, a flush, and a saturating mispredict counter.

Parameters:
- ENTRIES, 16, BTB/pattern-table depth; power of two, 4..256; IDX_W = log2(ENTRIES).
- ADDR_W, 32, width of address keys and targets.
- TAG_W, 8, stored tag bits taken from key[IDX_W+TAG_W:IDX_W+1]; requires IDX_W+TAG_W < ADDR_W.
- CNT_W, 2, saturating counter width, 1..4.
- MODE, 0, pattern-table indexing: 0 = bimodal (counter index = idx), 1 = gshare (counter index = idx XOR ghr[IDX_W-1:0]).
- GHR_W, 8, global history length; requires GHR_W >= IDX_W (meaningful only when MODE=1).
- PERF_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- stall_i  in  1  pipeline stall; blocks updates, counter increments and history shifts.
- flush_i  in  1  one-cycle pulse invalidating all BTB entries.
- rd_addr_2_i  in  ADDR_W  lookup key, compressed path (PC+2).
- rd_hit_2_o  out  1  predict-taken for key 2.
- rd_target_2_o  out  ADDR_W  predicted target for key 2.
- rd_addr_4_i  in  ADDR_W  lookup key, 32-bit path (PC+4).
- rd_hit_4_o  out  1  predict-taken for key 4.
- rd_target_4_o  out  ADDR_W  predicted target for key 4.
- upd_valid_i  in  1  resolved branch present in EX.
- upd_addr_i  in  ADDR_W  key of the resolved branch (its PC+2 or PC+4).
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_miss_i  in  1  the prediction was wrong.
- ghr_o  out  GHR_W  committed global history.
- miss_cnt_o  out  PERF_W  saturating mispredict count.

Behaviour:
- Index and tag: idx = key[IDX_W:1] (halfword granule); tag = key[IDX_W+TAG_W:IDX_W+1].
- Per BTB entry: valid, tag, target. The pattern table holds ENTRIES counters of CNT_W bits.
- Lookup is purely combinational, zero latency. hit = valid[idx] & (tag match) & counter MSB; target = stored target, or 0 when hit=0. Both ports are fully independent.
- Reset (async): all valid=0; every counter = 2^(CNT_W-1)-1 (weakly not-taken); ghr=0; miss_cnt=0. Hence all hit outputs = 0 and all targets = 0.
- An update applies at the clock edge only when upd_valid_i & !stall_i & !flush_i.
- Taken outcome:
  - Write valid=1, tag, target.
  - If the tag previously matched (or MODE=1), counter +1, saturating at 2^CNT_W-1.
  - On a new allocation in MODE=0, counter = 2^(CNT_W-1) (weakly taken).
- Not-taken outcome:
  - MODE=0: counter -1 (saturating at 0) only if the tag matches; otherwise no change and no allocation.
  - MODE=1: counter -1 always; the BTB entry is unchanged.
- MODE=1 only: ghr <= {ghr[GHR_W-2:0], upd_taken_i} on each applied update. The counter index for both update and lookup uses the current committed ghr.
- miss_cnt increments on an applied update with upd_miss_i=1 and holds at all-ones.
- Read during write to the same idx returns pre-update contents; the new contents are visible the next cycle.
- flush_i: valid bits all cleared next edge; counters, ghr and miss_cnt are kept. A same-cycle update is dropped (flush wins). Flush is honoured even under stall.
- stall_i blocks updates, the ghr shift and the miss_cnt increment; lookups continue.
- Aliasing: different keys with the same idx and tag share an entry; this is accepted.

Decomposition:
- Shared package: counter init constants (WEAK_NT, WEAK_T), a clog2 function, and a mode enum (BIMODAL=0, GSHARE=1).
- One natural sub-module, sat_counter_table: ENTRIES x CNT_W array with two read indices, one write index and an inc/dec request, with saturation built in. The BTB arrays, ghr and perf counter stay in the top.

Test Plan (defaults unless stated):
- Reset: assert rst mid-run after entries are written -> rd_hit_2_o = rd_hit_4_o = 0 immediately (asynchronous); after release, lookup of 0x104 misses.
- Allocation: update addr=0x104, taken=1, target=0x200 -> same cycle rd_addr_4_i=0x104 still misses; next cycle hit_4=1, target_4=0x200, counter=2.
- Saturation and decay: on 0x104, three more taken, then not-taken once -> still hit. A second not-taken gives counter=1 -> miss.
- Aliasing and tag mismatch: after 0x104 is allocated, not-taken update on 0x124 (same idx, different tag) -> entry for 0x104 unchanged, still hits.
- Flush vs. update: flush_i and a taken update to 0x300 in the same cycle -> all lookups miss next cycle; 0x300 is not allocated.
- Stall and perf counter:
  - 3 updates with upd_miss_i=1, one of them during stall_i=1 -> miss_cnt_o=2.
  - MODE=1: taken, taken, not-taken applied -> ghr_o=0x06.
  - PERF_W=2: 5 applied misses -> miss_cnt_o=3.

Source files
------------

// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch target buffer / pattern table predictor.
package branch_predictor_btb_pkg;

   // Pattern-table indexing scheme.
   typedef enum logic {
      BIMODAL = 1'b0,
      GSHARE  = 1'b1
   } mode_e;

   // Ceiling log2 usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Weakly not-taken counter value: 2^(w-1)-1.
   function automatic int weak_nt(input int cnt_w);
      return (32'sd1 <<< (cnt_w - 1)) - 32'sd1;
   endfunction

   // Weakly taken counter value: 2^(w-1).
   function automatic int weak_t(input int cnt_w);
      return (32'sd1 <<< (cnt_w - 1));
   endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter_table.sv
// ENTRIES x CNT_W table of saturating counters: two read ports, one
// write port taking a set, increment or decrement request.
module sat_counter_table
   import branch_predictor_btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int CNT_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_a,
   input  logic [IDX_W-1:0] rd_idx_b,
   output logic [CNT_W-1:0] rd_cnt_a,
   output logic [CNT_W-1:0] rd_cnt_b,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             inc,
   input  logic             dec,
   input  logic             set,
   input  logic [CNT_W-1:0] set_val
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(weak_nt(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt [ENTRIES];
   logic [CNT_W-1:0] cur;
   logic [CNT_W-1:0] nxt;

   assign rd_cnt_a = cnt[rd_idx_a];
   assign rd_cnt_b = cnt[rd_idx_b];
   assign cur      = cnt[wr_idx];

   // Next value of the addressed counter with saturation at both ends.
   always_comb begin
      nxt = cur;
      if (set) begin
         nxt = set_val;
      end else if (inc && (cur != CNT_MAX)) begin
         nxt = cur + CNT_ONE;
      end else if (dec && (cur != CNT_MIN)) begin
         nxt = cur - CNT_ONE;
      end else begin
         nxt = cur;
      end
   end

   // Counter storage; reset to weakly not-taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt[i] <= CNT_INIT;
         end
      end else if (set || inc || dec) begin
         cnt[wr_idx] <= nxt;
      end
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with a saturating-counter pattern
// table, two combinational lookup ports, one EX update port, optional
// gshare indexing and a saturating mispredict counter.
module branch_predictor_btb
   import branch_predictor_btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 32,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2,
   parameter int MODE    = 0,
   parameter int GHR_W   = 8,
   parameter int PERF_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] rd_addr_2_i,
   output logic              rd_hit_2_o,
   output logic [ADDR_W-1:0] rd_target_2_o,
   input  logic [ADDR_W-1:0] rd_addr_4_i,
   output logic              rd_hit_4_o,
   output logic [ADDR_W-1:0] rd_target_4_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_addr_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_miss_i,
   output logic [GHR_W-1:0]  ghr_o,
   output logic [PERF_W-1:0] miss_cnt_o
);

   localparam int               IDX_W     = clog2(ENTRIES);
   localparam bit               GSHARE_EN = (MODE == int'(GSHARE));
   localparam logic [CNT_W-1:0] CNT_WT    = CNT_W'(weak_t(CNT_W));
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
   logic [GHR_W-1:0]   ghr;
   logic [PERF_W-1:0]  miss_cnt;

   logic [IDX_W-1:0] idx_2, idx_4, idx_u;
   logic [IDX_W-1:0] cidx_2, cidx_4, cidx_u;
   logic [TAG_W-1:0] tag_2, tag_4, tag_u;
   logic [CNT_W-1:0] cnt_2, cnt_4;
   logic             apply, match_u, cnt_inc, cnt_dec, cnt_set;
   logic             unused_bits;

   // Pattern-table index: plain idx, or idx folded with committed history.
   function automatic logic [IDX_W-1:0] cnt_index(input logic [IDX_W-1:0] i,
                                                  input logic [GHR_W-1:0] h);
      if (GSHARE_EN) begin
         return i ^ h[IDX_W-1:0];
      end else begin
         return i;
      end
   endfunction

   assign idx_2  = rd_addr_2_i[IDX_W:1];
   assign idx_4  = rd_addr_4_i[IDX_W:1];
   assign idx_u  = upd_addr_i[IDX_W:1];
   assign tag_2  = rd_addr_2_i[IDX_W+TAG_W:IDX_W+1];
   assign tag_4  = rd_addr_4_i[IDX_W+TAG_W:IDX_W+1];
   assign tag_u  = upd_addr_i[IDX_W+TAG_W:IDX_W+1];
   assign cidx_2 = cnt_index(idx_2, ghr);
   assign cidx_4 = cnt_index(idx_4, ghr);
   assign cidx_u = cnt_index(idx_u, ghr);

   // Key bits outside index and tag do not take part in lookup.
   assign unused_bits = ^{rd_addr_2_i[ADDR_W-1:IDX_W+TAG_W+1], rd_addr_2_i[0],
                          rd_addr_4_i[ADDR_W-1:IDX_W+TAG_W+1], rd_addr_4_i[0],
                          upd_addr_i[ADDR_W-1:IDX_W+TAG_W+1], upd_addr_i[0]};

   sat_counter_table #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W),
      .CNT_W   (CNT_W)
   ) u_pht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_a (cidx_2),
      .rd_idx_b (cidx_4),
      .rd_cnt_a (cnt_2),
      .rd_cnt_b (cnt_4),
      .wr_idx   (cidx_u),
      .inc      (cnt_inc),
      .dec      (cnt_dec),
      .set      (cnt_set),
      .set_val  (CNT_WT)
   );

   // Zero-latency lookups; a miss always reports a zero target.
   always_comb begin
      rd_hit_2_o    = valid[idx_2] & (tag_mem[idx_2] == tag_2) & cnt_2[CNT_W-1];
      rd_hit_4_o    = valid[idx_4] & (tag_mem[idx_4] == tag_4) & cnt_4[CNT_W-1];
      rd_target_2_o = rd_hit_2_o ? tgt_mem[idx_2] : {ADDR_W{1'b0}};
      rd_target_4_o = rd_hit_4_o ? tgt_mem[idx_4] : {ADDR_W{1'b0}};
   end

   // Decide the counter action for a resolved branch; flush drops the update.
   always_comb begin
      apply   = upd_valid_i & ~stall_i & ~flush_i;
      match_u = valid[idx_u] & (tag_mem[idx_u] == tag_u);
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;
      cnt_set = 1'b0;
      if (apply) begin
         if (upd_taken_i) begin
            if (GSHARE_EN || match_u) begin
               cnt_inc = 1'b1;
            end else begin
               cnt_set = 1'b1;
            end
         end else begin
            if (GSHARE_EN || match_u) begin
               cnt_dec = 1'b1;
            end else begin
               cnt_dec = 1'b0;
            end
         end
      end else begin
         cnt_inc = 1'b0;
      end
   end

   // Entry valid bits: cleared by flush even when stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= {ENTRIES{1'b0}};
      end else if (flush_i) begin
         valid <= {ENTRIES{1'b0}};
      end else if (apply && upd_taken_i) begin
         valid[idx_u] <= 1'b1;
      end
   end

   // Tag and target storage, written on every applied taken outcome.
   always_ff @(posedge clk) begin
      if (apply && upd_taken_i) begin
         tag_mem[idx_u] <= tag_u;
         tgt_mem[idx_u] <= upd_target_i;
      end
   end

   // Committed global history, shifted only in gshare mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr <= {GHR_W{1'b0}};
      end else if (apply && GSHARE_EN) begin
         ghr <= {ghr[GHR_W-2:0], upd_taken_i};
      end
   end

   // Mispredict counter, holding at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_cnt <= {PERF_W{1'b0}};
      end else if (apply && upd_miss_i && (miss_cnt != PERF_MAX)) begin
         miss_cnt <= miss_cnt + PERF_W'(1);
      end
   end

   assign ghr_o      = ghr;
   assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench: directed table, multi-cycle corner sequences and
// randomized traffic compared against a behavioural predictor model.
module tb_branch_predictor_btb;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] ra2, ra4;
   logic        uv, ut, um;
   logic [31:0] ua, utg;

   logic        h2, h4, h2g, h4g, h2p, h4p;
   logic [31:0] t2, t4, t2g, t4g, t2p, t4p;
   logic [7:0]  ghr, ghr_g, ghr_p;
   logic [15:0] mc, mc_g;
   logic [1:0]  mc_p;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_predictor_btb dut (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .rd_addr_2_i(ra2), .rd_hit_2_o(h2), .rd_target_2_o(t2),
      .rd_addr_4_i(ra4), .rd_hit_4_o(h4), .rd_target_4_o(t4),
      .upd_valid_i(uv), .upd_addr_i(ua), .upd_taken_i(ut),
      .upd_target_i(utg), .upd_miss_i(um), .ghr_o(ghr), .miss_cnt_o(mc));

   branch_predictor_btb #(.MODE(1)) dut_g (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .rd_addr_2_i(ra2), .rd_hit_2_o(h2g), .rd_target_2_o(t2g),
      .rd_addr_4_i(ra4), .rd_hit_4_o(h4g), .rd_target_4_o(t4g),
      .upd_valid_i(uv), .upd_addr_i(ua), .upd_taken_i(ut),
      .upd_target_i(utg), .upd_miss_i(um), .ghr_o(ghr_g), .miss_cnt_o(mc_g));

   branch_predictor_btb #(.PERF_W(2)) dut_p (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .rd_addr_2_i(ra2), .rd_hit_2_o(h2p), .rd_target_2_o(t2p),
      .rd_addr_4_i(ra4), .rd_hit_4_o(h4p), .rd_target_4_o(t4p),
      .upd_valid_i(uv), .upd_addr_i(ua), .upd_taken_i(ut),
      .upd_target_i(utg), .upd_miss_i(um), .ghr_o(ghr_p), .miss_cnt_o(mc_p));

   // ---------------- behavioural model (16 entries, 8-bit tag, 2-bit counters)
   bit          m_valid [16];
   int          m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_cnt0  [16];
   int          m_cnt1  [16];
   int          m_ghr, m_miss, m_miss2;

   function automatic int kidx(input logic [31:0] k);
      return int'((k >> 1) & 32'hF);
   endfunction

   function automatic int ktag(input logic [31:0] k);
      return int'((k >> 5) & 32'hFF);
   endfunction

   function automatic bit m_hit(input int mode, input logic [31:0] k);
      int i, c;
      i = kidx(k);
      c = (mode == 1) ? m_cnt1[i ^ (m_ghr % 16)] : m_cnt0[i];
      return m_valid[i] && (m_tag[i] == ktag(k)) && (c >= 2);
   endfunction

   function automatic logic [31:0] m_target(input int mode, input logic [31:0] k);
      return m_hit(mode, k) ? m_tgt[kidx(k)] : 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_cnt0[i] = 1; m_cnt1[i] = 1;
      end
      m_ghr = 0; m_miss = 0; m_miss2 = 0;
   endtask

   task automatic model_edge();
      int i, g;
      bit match;
      if (flush) begin
         for (int j = 0; j < 16; j++) m_valid[j] = 1'b0;
      end else if (uv && !stall) begin
         i = kidx(ua);
         g = i ^ (m_ghr % 16);
         match = m_valid[i] && (m_tag[i] == ktag(ua));
         if (ut) begin
            m_cnt0[i] = match ? ((m_cnt0[i] < 3) ? m_cnt0[i] + 1 : 3) : 2;
            m_cnt1[g] = (m_cnt1[g] < 3) ? m_cnt1[g] + 1 : 3;
            m_valid[i] = 1'b1; m_tag[i] = ktag(ua); m_tgt[i] = utg;
         end else begin
            if (match && m_cnt0[i] > 0) m_cnt0[i] = m_cnt0[i] - 1;
            if (m_cnt1[g] > 0) m_cnt1[g] = m_cnt1[g] - 1;
         end
         m_ghr = ((m_ghr << 1) | int'(ut)) % 256;
         if (um) begin
            if (m_miss < 65535) m_miss = m_miss + 1;
            if (m_miss2 < 3) m_miss2 = m_miss2 + 1;
         end
      end
   endtask

   // ---------------- helpers
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      if (rst) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] a, input logic t,
                          input logic [31:0] tg, input logic m, input logic s, input logic f);
      uv = v; ua = a; ut = t; utg = tg; um = m; stall = s; flush = f;
   endtask

   task automatic check_model();
      check("rand_hit2",    64'(h2),    64'(m_hit(0, ra2)));
      check("rand_tgt2",    64'(t2),    64'(m_target(0, ra2)));
      check("rand_hit4",    64'(h4),    64'(m_hit(0, ra4)));
      check("rand_tgt4",    64'(t4),    64'(m_target(0, ra4)));
      check("rand_g_hit2",  64'(h2g),   64'(m_hit(1, ra2)));
      check("rand_g_tgt2",  64'(t2g),   64'(m_target(1, ra2)));
      check("rand_g_hit4",  64'(h4g),   64'(m_hit(1, ra4)));
      check("rand_g_tgt4",  64'(t4g),   64'(m_target(1, ra4)));
      check("rand_ghr_g",   64'(ghr_g), 64'(m_ghr));
      check("rand_ghr_bim", 64'(ghr),   64'h0);
      check("rand_miss",    64'(mc),    64'(m_miss));
      check("rand_miss_p",  64'(mc_p),  64'(m_miss2));
   endtask

   typedef struct {
      logic        uv;
      logic [31:0] ua;
      logic        ut;
      logic [31:0] utg;
      logic        fl;
      logic [31:0] ra4;
      logic        eh4;
      logic [31:0] et4;
      logic [31:0] ra2;
      logic        eh2;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [31:0] a, input logic t,
                               input logic [31:0] tg, input logic f, input logic [31:0] r4,
                               input logic e4, input logic [31:0] et, input logic [31:0] r2,
                               input logic e2);
      vec_t x;
      x.uv = v; x.ua = a; x.ut = t; x.utg = tg; x.fl = f;
      x.ra4 = r4; x.eh4 = e4; x.et4 = et; x.ra2 = r2; x.eh2 = e2;
      return x;
   endfunction

   vec_t tbl [14];

   initial begin
      // Directed table: allocation, saturation/decay, aliasing, flush vs update.
      tbl[0]  = mk(1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h0,   32'h300, 1'b0);
      tbl[1]  = mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h200, 32'h104, 1'b1);
      tbl[2]  = mk(1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200, 32'h124, 1'b0);
      tbl[3]  = tbl[2];
      tbl[4]  = tbl[2];
      tbl[5]  = mk(1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h200, 32'h300, 1'b0);
      tbl[6]  = tbl[5];
      tbl[7]  = mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0,   32'h104, 1'b0);
      tbl[8]  = mk(1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h0,   32'h300, 1'b0);
      tbl[9]  = mk(1'b1, 32'h124, 1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h200, 32'h124, 1'b0);
      tbl[10] = mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h200, 32'h104, 1'b1);
      tbl[11] = mk(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 32'h104, 1'b1, 32'h200, 32'h300, 1'b0);
      tbl[12] = mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0,   32'h300, 1'b0);
      tbl[13] = mk(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h0,   32'h104, 1'b0);

      rst = 1'b1; ra2 = 32'h104; ra4 = 32'h104;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("reset_hit2", 64'(h2),    64'h0);
      check("reset_hit4", 64'(h4),    64'h0);
      check("reset_tgt4", 64'(t4),    64'h0);
      check("reset_ghr",  64'(ghr_g), 64'h0);
      check("reset_miss", 64'(mc),    64'h0);

      for (int r = 0; r < 14; r++) begin
         set_upd(tbl[r].uv, tbl[r].ua, tbl[r].ut, tbl[r].utg, 1'b0, 1'b0, tbl[r].fl);
         ra4 = tbl[r].ra4; ra2 = tbl[r].ra2;
         #1;
         check($sformatf("tbl%0d_hit4", r), 64'(h4), 64'(tbl[r].eh4));
         check($sformatf("tbl%0d_tgt4", r), 64'(t4), 64'(tbl[r].et4));
         check($sformatf("tbl%0d_hit2", r), 64'(h2), 64'(tbl[r].eh2));
         tick();
      end

      // Asynchronous reset mid-run with a live entry.
      set_upd(1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      ra4 = 32'h104; ra2 = 32'h104;
      #1;
      check("pre_rst_hit4", 64'(h4), 64'h1);
      rst = 1'b1;
      #1;
      check("async_rst_hit4", 64'(h4), 64'h0);
      check("async_rst_hit2", 64'(h2), 64'h0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_hit4", 64'(h4), 64'h0);

      // Stall blocks perf and history; gshare history and narrow perf counter.
      set_upd(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0); tick();
      set_upd(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0); tick();
      set_upd(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0); tick();
      set_upd(1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0); tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("stall_miss_cnt", 64'(mc),    64'h2);
      check("gshare_ghr",     64'(ghr_g), 64'h6);
      check("bimodal_ghr",    64'(ghr),   64'h0);
      for (int n = 0; n < 3; n++) begin
         set_upd(1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
      end
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("perf2_saturate", 64'(mc_p), 64'h3);
      check("perf16_count",   64'(mc),   64'h5);

      // Randomized traffic against the model.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         ra2 = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 15)) << 1);
         ra4 = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 15)) << 1);
         set_upd(($urandom_range(0, 3) != 0),
                 (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 15)) << 1)
                    | 32'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0),
                 32'($urandom) & 32'hFFFF_FFFE,
                 ($urandom_range(0, 1) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 24) == 0));
         #1;
         check_model();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
